if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  Instruction-fetch stage: the producer side of the decoder's pc_i/inst_i input. Generates the PC
//  and issues word fetches on a req/gnt/rvalid instruction-memory port. Buffers returned words in
//  a small prefetch FIFO and presents one {pc, inst} per cycle to ID through a registered output.
//  Supports pipeline stall and branch/exception redirect (flush).
// PARAMETERS
//  RESET_PC    32'h0000_0000  first fetch address after reset
//  DEPTH       2              prefetch FIFO entries; also max (outstanding + buffered) credits
// PORTS
//  clk            in   1   clock, all state on rising edge
//  rst            in   1   reset
//  stall_i        in   1   ID/ctrl hold request; output register must not change
//  flush_i        in   1   redirect; discards all in-flight and buffered instructions
//  flush_pc_i     in   32  redirect target, sampled when flush_i=1
//  imem_req_o     out  1   fetch request
//  imem_addr_o    out  32  fetch byte address, word aligned
//  imem_gnt_i     in   1   request accepted this cycle (req & gnt)
//  imem_rvalid_i  in   1   one response per accepted request, in order, >=1 cycle after gnt
//  imem_rdata_i   in   32  instruction word, valid with rvalid
//  pc_o           out  32  PC of inst_o, to ID
//  inst_o         out  32  instruction to ID; 32'h0 (sll $0,$0,0 = NOP) when invalid
//  inst_valid_o   out  1   inst_o carries a real fetched instruction
// BEHAVIOUR
//  Reset: rst is synchronous, active-high. While rst=1 and on the cycle after: pc_o=0, inst_o=0,
//   inst_valid_o=0, imem_req_o=0, fetch_pc=RESET_PC, FIFO empty, outstanding=0, discard=0, state=RUN.
//   Reset mid-operation aborts everything; memory shares rst, so no stale rvalid is expected.
//  State machine: RUN (issue fetches) / DRAIN (flushed, dropping stale responses).
//   RUN->DRAIN: flush_i=1 and (outstanding + accepted-this-cycle) > 0; discard loads that sum.
//   RUN->RUN on flush with nothing in flight. DRAIN->RUN when the final discarded rvalid arrives
//   (discard 1->0); a flush in DRAIN reloads fetch_pc and keeps counting.
//  Request: imem_req_o = (state==RUN) & !flush_i & (outstanding + fifo_count < DEPTH).
//   imem_addr_o = fetch_pc, stable until gnt. Withdrawing req without gnt is legal only on flush.
//   On req&gnt: fetch_pc += 4 (wraps at 2^32), outstanding += 1.
//  Response: rvalid decrements outstanding (or discard in DRAIN, data dropped). In RUN the word
//   is pushed into the FIFO with its PC (PC tracked by a response counter starting at the
//   fetch address). Credit rule guarantees no overflow; push-when-full is an assertion failure.
//  Output register (updates on every edge with stall_i=0):
//   - flush_i=1: inst_valid_o=0, inst_o=0, pc_o holds; FIFO cleared. Flush beats stall.
//   - FIFO non-empty: pop head -> {pc_o, inst_o}, inst_valid_o=1.
//   - FIFO empty and rvalid in RUN: bypass rdata directly (no FIFO write), inst_valid_o=1.
//   - otherwise bubble: inst_valid_o=0, inst_o=0, pc_o holds.
//   With stall_i=1 and no flush: pc_o/inst_o/inst_valid_o hold; responses still fill the FIFO.
//  Latency: rvalid in cycle N -> visible on outputs in N+1 when unstalled and FIFO empty.
//  Throughput: one instruction per cycle with gnt=1 and 1-cycle rvalid.
//  Simultaneous push and pop in the same cycle are legal; FIFO count unchanged.
//  flush_pc_i bits[1:0] are ignored (forced 0).
// TESTING
//  1 rst=1 two cycles -> outputs 0, req=0; cycle after release req=1, addr=0x0.
//  2 gnt=1, rvalid 1 cycle later, rdata=addr|0xA000_0000 -> inst_valid_o every cycle from first
//    response, pc_o 0,4,8,..., inst_o matches; no gaps.
//  3 stall_i=1 for 3 cycles mid-stream -> outputs held, req drops once 2 credits used; after
//    release pc_o continues +4 with no lost or duplicated instruction.
//  4 flush_i=1, flush_pc_i=0x100 with 2 outstanding -> 2 stale rvalids dropped, no req during
//    DRAIN, next req addr=0x100, next valid pc_o=0x100.
//  5 gnt=0 for 4 cycles -> req held, imem_addr_o stable, inst_valid_o=0, then resumes in order.
//  6 rst=1 while stalled with full FIFO -> all outputs at reset values next cycle, refetch
//    from RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC generation, req/gnt/rvalid fetch port, prefetch FIFO
// and a registered {pc, inst} output toward the decoder.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);

  // state | meaning
  // RUN   | issuing fetches, responses go to FIFO or straight to the output
  // DRAIN | redirected; dropping responses that were in flight at the flush
  typedef enum logic {S_RUN, S_DRAIN} state_e;

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]     fifo_pc_q   [DEPTH];
  logic [31:0]     fifo_inst_q [DEPTH];
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;
  logic            valid_q, valid_d;

  logic            accept;
  logic            rsp_run;
  logic            fifo_empty;
  logic            fifo_full;
  logic            push;
  logic            pop;
  logic [CW:0]     credit_used;
  logic [CW-1:0]   outst_nx;
  logic [31:0]     redirect_pc;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign redirect_pc = flush_pc_i & 32'hFFFF_FFFC;
  assign credit_used = {1'b0, outst_q} + {1'b0, count_q};
  assign fifo_empty  = (count_q == '0);
  assign fifo_full   = (count_q == CW'(DEPTH));

  assign imem_req_o  = !rst && (state_q == S_RUN) && !flush_i && (credit_used < (CW+1)'(DEPTH));
  assign imem_addr_o = fetch_pc_q;

  assign accept  = imem_req_o & imem_gnt_i;
  assign rsp_run = imem_rvalid_i & (state_q == S_RUN);

  // A response bypasses the FIFO only when it can go straight to the output
  assign pop  = !stall_i && !flush_i && !fifo_empty;
  assign push = rsp_run && !flush_i && !(!stall_i && fifo_empty);

  assign outst_nx = outst_q + CW'(accept) - CW'(rsp_run);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q;
    discard_d  = discard_q;

    if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
    if (rsp_run) resp_pc_d = resp_pc_q + 32'd4;

    case (state_q)
      S_RUN: begin
        outst_d = outst_nx;
        if (flush_i) begin
          outst_d = '0;
          if (outst_nx != '0) begin
            state_d   = S_DRAIN;
            discard_d = outst_nx;
          end
        end
      end
      S_DRAIN: begin
        if (imem_rvalid_i) begin
          discard_d = discard_q - CW'(1);
          if (discard_q == CW'(1)) state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase

    if (flush_i) begin
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    if (flush_i) begin
      inst_d  = 32'h0;
      valid_d = 1'b0;
    end else if (!stall_i) begin
      if (!fifo_empty) begin
        pc_d    = fifo_pc_q[rd_ptr_q];
        inst_d  = fifo_inst_q[rd_ptr_q];
        valid_d = 1'b1;
      end else if (rsp_run) begin
        pc_d    = resp_pc_q;
        inst_d  = imem_rdata_i;
        valid_d = 1'b1;
      end else begin
        inst_d  = 32'h0;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RUN;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      pc_q       <= 32'h0;
      inst_q     <= 32'h0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      valid_q    <= valid_d;
    end
  end

  // FIFO storage needs no reset; count_q qualifies every entry
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]   <= resp_pc_q;
      fifo_inst_q[wr_ptr_q] <= imem_rdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      a_no_overflow: assert (!(fifo_full && !pop));
    end
  end

  assign pc_o         = pc_q;
  assign inst_o       = inst_q;
  assign inst_valid_o = valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: in-order memory model with optional response hold,
// hand-computed checkpoints plus an in-order PC/instruction stream check.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;

  if_fetch_unit #(.RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .flush_pc_i   (flush_pc_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .pc_o         (pc_o),
    .inst_o       (inst_o),
    .inst_valid_o (inst_valid_o)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        mem_hold = 1'b0;
  logic [31:0] q_addr[$];
  int          q_cyc[$];
  logic        last_req;
  logic [31:0] last_addr;
  logic [31:0] exp_pc = 32'h0;
  logic        in_t2 = 1'b0;
  logic        seen_valid = 1'b0;
  int          gaps = 0;
  logic [31:0] held_pc;
  logic [31:0] held_inst;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: memory drives this cycle's response, acceptance is recorded,
  // then outputs are inspected just after the edge.
  task automatic tick();
    logic c_stall, c_flush, c_rst;
    if (!mem_hold && q_addr.size() > 0 && q_cyc[0] < cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = q_addr[0] | 32'hA000_0000;
      void'(q_addr.pop_front());
      void'(q_cyc.pop_front());
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 32'hDEAD_BEEF;
    end
    #1;
    last_req  = imem_req_o;
    last_addr = imem_addr_o;
    if (imem_req_o && imem_gnt_i) begin
      q_addr.push_back(imem_addr_o);
      q_cyc.push_back(cyc);
    end
    c_stall = stall_i;
    c_flush = flush_i;
    c_rst   = rst;
    @(posedge clk);
    #1;
    cyc++;
    if (!inst_valid_o) check("nop_when_invalid", inst_o, 32'h0);
    if (!c_rst && !c_stall && !c_flush) begin
      if (inst_valid_o) begin
        check("stream_pc", pc_o, exp_pc);
        check("stream_inst", inst_o, exp_pc | 32'hA000_0000);
        exp_pc += 32'd4;
        seen_valid = 1'b1;
      end else if (in_t2 && seen_valid) begin
        gaps++;
      end
    end
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0; flush_pc_i = 32'h0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;

    // 1: reset
    tick(); tick();
    check("rst_pc", pc_o, 32'h0);
    check("rst_inst", inst_o, 32'h0);
    check("rst_valid", {31'b0, inst_valid_o}, 32'h0);
    check("rst_req", {31'b0, imem_req_o}, 32'h0);
    rst = 1'b0; imem_gnt_i = 1'b1;
    #1;
    check("post_rst_req", {31'b0, imem_req_o}, 32'h1);
    check("post_rst_addr", imem_addr_o, 32'h0);
    exp_pc = 32'h0;

    // 2: back-to-back stream
    in_t2 = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    in_t2 = 1'b0;
    check("t2_last_pc", pc_o, 32'h1C);
    check("t2_last_valid", {31'b0, inst_valid_o}, 32'h1);
    check("t2_gaps", gaps, 0);

    // 3: stall three cycles
    held_pc = pc_o; held_inst = inst_o;
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc_hold", pc_o, held_pc);
      check("stall_inst_hold", inst_o, held_inst);
      check("stall_valid_hold", {31'b0, inst_valid_o}, 32'h1);
      if (i > 0) check("stall_req_drop", {31'b0, last_req}, 32'h0);
    end
    stall_i = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("t3_resume_pc", pc_o, 32'h28);

    // 4: flush with two outstanding
    mem_hold = 1'b1;
    tick();
    tick();
    check("hold_req_full", {31'b0, last_req}, 32'h0);
    flush_i = 1'b1; flush_pc_i = 32'h0000_0103;
    exp_pc = 32'h100;
    tick();
    check("flush_req", {31'b0, last_req}, 32'h0);
    check("flush_valid", {31'b0, inst_valid_o}, 32'h0);
    check("flush_inst", inst_o, 32'h0);
    flush_i = 1'b0; mem_hold = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("drain_req", {31'b0, last_req}, 32'h0);
      check("drain_valid", {31'b0, inst_valid_o}, 32'h0);
    end
    #1;
    check("redirect_req", {31'b0, imem_req_o}, 32'h1);
    check("redirect_addr", imem_addr_o, 32'h100);
    tick();
    tick();
    check("redirect_pc_out", pc_o, 32'h100);
    check("redirect_valid", {31'b0, inst_valid_o}, 32'h1);

    // 5: no grant for four cycles
    imem_gnt_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("nognt_req", {31'b0, last_req}, 32'h1);
      check("nognt_addr", last_addr, 32'h108);
      if (i > 0) check("nognt_valid", {31'b0, inst_valid_o}, 32'h0);
    end
    imem_gnt_i = 1'b1;
    tick();
    tick();
    check("t5_resume_pc", pc_o, 32'h108);
    tick();
    check("t5_next_pc", pc_o, 32'h10C);

    // 6: reset while stalled with a full FIFO
    held_pc = pc_o;
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("t6_stall_hold", pc_o, held_pc);
    rst = 1'b1;
    tick();
    q_addr.delete();
    q_cyc.delete();
    check("t6_rst_pc", pc_o, 32'h0);
    check("t6_rst_inst", inst_o, 32'h0);
    check("t6_rst_valid", {31'b0, inst_valid_o}, 32'h0);
    check("t6_rst_req", {31'b0, imem_req_o}, 32'h0);
    rst = 1'b0; stall_i = 1'b0;
    exp_pc = 32'h0;
    #1;
    check("t6_refetch_req", {31'b0, imem_req_o}, 32'h1);
    check("t6_refetch_addr", imem_addr_o, 32'h0);
    tick();
    tick();
    check("t6_first_pc", pc_o, 32'h0);
    check("t6_first_valid", {31'b0, inst_valid_o}, 32'h1);
    tick();
    check("t6_second_pc", pc_o, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=%0d exp=done", cyc);
    $fatal(1);
  end

endmodule
